rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter sharing one downstream resource among eight requesters. It produces both a one-hot grant vector and the matching 3-bit encoded index, so the encoder that follows never receives a non-one-hot input. Each grant is held while the requester keeps asking, up to a bounded hold time, and then passes fairly to the next requester in rotation. It sits between the request sources and the shared 8-to-3 encoded select path.

## Interface
- MAX_HOLD, 15: maximum consecutive grant cycles per tenure; 0 = unlimited; range 0..15.
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous active-low reset.
- En  in  1  arbiter enable.
- req  in  8  request lines, bit i = requester i.
- gnt  out  8  one-hot grant, registered; all-zero when idle.
- gnt_idx  out  3  binary index of granted requester; 0 when gnt_valid=0.
- gnt_valid  out  1  high while any grant is asserted.
- preempt  out  1  one-cycle pulse when a grant is removed by hold timeout.

## Operation
- State machine with two states, IDLE and GRANT. Internal 3-bit round-robin pointer ptr. Internal 4-bit hold counter hcnt.
- IDLE:
  - If En=1 and req!=0, select the first set bit scanning ptr, ptr+1, ... wrapping modulo 8.
  - Register gnt=onehot(w), gnt_idx=w, gnt_valid=1, ptr=w+1 mod 8, hcnt=1.
  - Go to GRANT.
  - Otherwise outputs stay cleared.
- GRANT (holder h):
  - Release when req[h]=0 or En=0. Clear gnt, gnt_idx and gnt_valid, then go to IDLE. No preempt.
  - Timeout when MAX_HOLD!=0, hcnt==MAX_HOLD and req[h]=1. Clear outputs, pulse preempt=1 for one cycle, then go to IDLE.
  - Otherwise hcnt increments, saturating at 15, and the grant is held.
  - Requests from other requesters are ignored while in GRANT.
- Release and timeout happening together: the release takes priority, so no preempt.
- A preempted requester keeps its request asserted and gets its next grant only after the rotation reaches it again. Because ptr has already moved past it, other pending requesters win first.
- gnt is always zero or one-hot, and gnt_idx always equals the encoded gnt. These two properties are invariants.
- Reset (Resetn=0, asynchronous, at any time including mid-grant):
  - gnt=0, gnt_idx=0, gnt_valid=0, preempt=0.
  - ptr=0, hcnt=0, state=IDLE.
  - The first grant after reset favours requester 0.

## Timing
- All outputs are registered. No combinational path from req or En to any output.
- Grant latency: req sampled at edge k while in IDLE → gnt visible after edge k.
- Release latency: req[h] drops before edge k → gnt clears after edge k.
- At least one IDLE cycle separates consecutive grants. Back-to-back grant turnaround is 2 cycles.
- Maximum tenure is MAX_HOLD cycles with gnt high. preempt is high during the single cycle after the last grant cycle, together with gnt=0.
- Worst-case wait for a continuously requesting input with MAX_HOLD=M: 7*(M+1) cycles before its own grant.
- En=0 while idle blocks new grants. En=0 while in GRANT releases the grant at the next edge.

## Test plan
- Reset, then req=8'b0000_0001 with En=1 → one cycle later gnt=8'h01, gnt_idx=0, gnt_valid=1. Drop req → next cycle gnt=0, gnt_valid=0, preempt=0.
- Rotation: after reset, hold req=8'hFF and release each holder after 2 cycles → grant order 0,1,2,...,7,0. gnt_idx matches each time and gnt is one-hot in every cycle.
- Timeout with MAX_HOLD=3: req=8'h24 held continuously → gnt=8'h04 for exactly 3 cycles, then gnt=0 with preempt=1 for 1 cycle. Next grant is gnt=8'h20 (idx 5), and after it times out, idx 2 again.
- Wrap and pointer: grant requester 7 and release it. Then req=8'h81 → requester 0 wins (ptr wrapped to 0), not requester 7.
- Enable: En=0 with req=8'h10 → no grant. Raise En → gnt=8'h10 one cycle later. Drop En mid-grant → gnt=0 at the next edge, with no preempt.
- Async reset mid-grant: assert Resetn=0 between clock edges while gnt=8'h40 → all outputs 0 immediately without waiting for an edge. After Resetn=1 with req=8'hC0 → idx 6 wins (ptr=0, first set bit at or after 0 is 6).

Source files
------------

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, encoded index,
// bounded grant tenure and a one-cycle preempt pulse on hold timeout.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [7:0] req_i,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       preempt_o
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic       preempt_q, preempt_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic       holder_req;
  logic       release_c;
  logic       timeout_c;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    logic [2:0] cand;
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign holder_req = req_i[idx_q];
  assign release_c  = !holder_req || !en_i;
  // Release wins over timeout, so timeout is only taken with the request still up.
  assign timeout_c  = (MAX_HOLD != 0) && (hcnt_q == HOLD_LIM) && holder_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i && win_found) state_d = GRANT;
      GRANT:   if (release_c || timeout_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    gnt_d     = 8'h00;
    idx_d     = 3'd0;
    vld_d     = 1'b0;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && win_found) begin
          gnt_d  = 8'h01 << win_idx;
          idx_d  = win_idx;
          vld_d  = 1'b1;
          ptr_d  = win_idx + 3'd1;
          hcnt_d = 4'd1;
        end
      end
      GRANT: begin
        if (release_c) begin
          preempt_d = 1'b0;
        end else if (timeout_c) begin
          preempt_d = 1'b1;
        end else begin
          gnt_d  = gnt_q;
          idx_d  = idx_q;
          vld_d  = 1'b1;
          hcnt_d = (hcnt_q == 4'hF) ? hcnt_q : hcnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= 3'd0;
      hcnt_q    <= 4'd0;
      gnt_q     <= 8'h00;
      idx_q     <= 3'd0;
      vld_q     <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = vld_q;
  assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with MAX_HOLD=3: reset, rotation, timeout,
// pointer wrap, enable gating and asynchronous reset mid-grant.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  rr_arbiter8 #(.MAX_HOLD(3)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .req_i       (req),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .preempt_o   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                           input logic ev, input logic ep);
    check({tag, ".gnt"},     gnt,              eg);
    check({tag, ".idx"},     {5'd0, gnt_idx},  {5'd0, ei});
    check({tag, ".valid"},   {7'd0, gnt_valid}, {7'd0, ev});
    check({tag, ".preempt"}, {7'd0, preempt},   {7'd0, ep});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] one;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    step();
    step();
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Single requester grant and release
    en  = 1'b1;
    req = 8'h01;
    step();
    check_out("single_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step();
    check_out("single_release", 8'h00, 3'd0, 1'b0, 1'b0);

    // Rotation 0..7,0 with each holder released after two cycles
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      one = 8'h01 << (i % 8);
      step();
      check_out($sformatf("rot%0d_grant", i), one, 3'(i % 8), 1'b1, 1'b0);
      step();
      check_out($sformatf("rot%0d_hold", i), one, 3'(i % 8), 1'b1, 1'b0);
      req = 8'hFF & ~one;
      step();
      check_out($sformatf("rot%0d_release", i), 8'h00, 3'd0, 1'b0, 1'b0);
      req = 8'hFF;
    end

    // Timeout with MAX_HOLD=3 alternating between requesters 2 and 5
    do_reset();
    req = 8'h24;
    step(); check_out("to_a1", 8'h04, 3'd2, 1'b1, 1'b0);
    step(); check_out("to_a2", 8'h04, 3'd2, 1'b1, 1'b0);
    step(); check_out("to_a3", 8'h04, 3'd2, 1'b1, 1'b0);
    step(); check_out("to_a_preempt", 8'h00, 3'd0, 1'b0, 1'b1);
    step(); check_out("to_b1", 8'h20, 3'd5, 1'b1, 1'b0);
    step(); check_out("to_b2", 8'h20, 3'd5, 1'b1, 1'b0);
    step(); check_out("to_b3", 8'h20, 3'd5, 1'b1, 1'b0);
    step(); check_out("to_b_preempt", 8'h00, 3'd0, 1'b0, 1'b1);
    step(); check_out("to_c1", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h00;
    step(); check_out("to_c_release", 8'h00, 3'd0, 1'b0, 1'b0);

    // Pointer wraps from 7 back to 0
    do_reset();
    req = 8'h80;
    step(); check_out("wrap_g7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h00;
    step(); check_out("wrap_rel7", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h81;
    step(); check_out("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step();

    // Enable gating
    en  = 1'b0;
    req = 8'h10;
    step(); check_out("en_off1", 8'h00, 3'd0, 1'b0, 1'b0);
    step(); check_out("en_off2", 8'h00, 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    step(); check_out("en_on", 8'h10, 3'd4, 1'b1, 1'b0);
    en = 1'b0;
    step(); check_out("en_drop", 8'h00, 3'd0, 1'b0, 1'b0);
    en  = 1'b1;
    req = 8'h00;
    step();

    // Asynchronous reset between edges while requester 6 holds the grant
    do_reset();
    req = 8'h40;
    step(); check_out("ar_g6", 8'h40, 3'd6, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("ar_async", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'hC0;
    #2;
    rst_n = 1'b1;
    step(); check_out("ar_after", 8'h40, 3'd6, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
